wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writers:
  - the in-order pipeline writeback result, i.e. the output of the WB-stage mux;
  - a long-latency unit (mul/div) that returns results through a valid/ready handshake.
- Holds at most one deferred long-latency result and resolves write-after-write conflicts.
- Forces a one-cycle pipeline stall when a deferred result has waited too long.
- Sits between the WB stage and the register file; its pending status goes to the hazard unit.

Parameters:
- WIDTH, 32, data width of the writeback value.
- REG_BITS, 5, width of a register index.
- MAX_WAIT, 4, cycles a buffered result may wait before the pipeline is stalled. Legal range is 1..15.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- pipe_we, input, 1, pipeline requests a write this cycle.
- pipe_rd, input, REG_BITS, pipeline destination register.
- pipe_data, input, WIDTH, pipeline writeback data.
- ll_valid, input, 1, long-latency result is available.
- ll_ready, output, 1, arbiter accepts the long-latency result.
- ll_rd, input, REG_BITS, long-latency destination register.
- ll_data, input, WIDTH, long-latency result data.
- rf_we, output, 1, register-file write enable (registered).
- rf_waddr, output, REG_BITS, register-file write address (registered).
- rf_wdata, output, WIDTH, register-file write data (registered).
- pipe_stall, output, 1, freezes the WB stage for one cycle.
- pend_valid, output, 1, a buffered long-latency result is pending.
- pend_rd, output, REG_BITS, destination register of the pending result.
- drop_cnt, output, CNT_W, count of long-latency writes discarded due to WAW.

Behaviour:
- Reset (asynchronous, rst_n low):
  - all outputs 0; state IDLE; buffer invalid; wait counter 0; drop_cnt 0.
  - Reset asserted during HOLD or FORCE discards the buffered result; no write is issued.
- Terms:
  - A pipeline commit is pipe_we=1, pipe_rd≠0 and pipe_stall=0.
  - An LL handshake is ll_valid=1 and ll_ready=1.
  - ll_ready = (state==IDLE), a Moore output.
- Latency: every winning write appears on rf_* one cycle after the deciding edge. rf_we=0 when nothing wins.
- Priority per cycle:
  - FORCE: buffer first.
  - Otherwise: pipeline commit, then buffer, then direct LL handshake.
- State IDLE:
  - LL handshake with no pipeline commit: the LL result is written directly; stay IDLE.
  - LL handshake together with a pipeline commit: the pipeline writes and the LL result is captured into the buffer. Go to HOLD with wait counter 0.
  - Exception: if ll_rd==pipe_rd, the LL result is treated as older. It is accepted but discarded, drop_cnt increments, and the state stays IDLE.
  - ll_rd==0: accepted and discarded silently, with no drop_cnt increment.
- State HOLD:
  - No pipeline commit: the buffer is written; go to IDLE.
  - Pipeline commit with pipe_rd==buf_rd: the buffer is invalidated (WAW), drop_cnt increments; go to IDLE.
  - Pipeline commit to a different rd: the wait counter increments. When the counter reaches MAX_WAIT, go to FORCE.
- State FORCE:
  - pipe_stall=1 (Moore).
  - The buffer is written; pipe_we is ignored; the upstream stage holds its request. Go to IDLE.
- Outputs pend_valid and pend_rd reflect the buffer register directly.
- drop_cnt saturates at 2^CNT_W−1.
- Writes to x0 never reach rf_we from either source.

Decomposition:
- Shared package wb_pkg:
  - state encoding: IDLE=2'd0, HOLD=2'd1, FORCE=2'd2;
  - REG_BITS default;
  - the x0 constant.
- One natural sub-module, wb_hold_buf: a one-entry buffer of {valid, rd, data} with capture/clear/invalidate controls. The FSM, priority logic and counters stay in the top module.

Test Plan:
- LL only: ll_valid=1, ll_rd=7, ll_data=0xDEADBEEF, pipe_we=0 → next cycle rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF; ll_ready stays 1.
- Collision: pipe_we=1, pipe_rd=3, data 0x11 and LL rd=9, data 0x22 in the same cycle → rf writes r3=0x11, then next cycle r9=0x22; pend_valid high for 1 cycle.
- Starvation: buffer r9 pending while the pipeline commits to r1..r4 on 4 consecutive cycles (MAX_WAIT=4) → pipe_stall=1 for exactly one cycle, r9 written in that cycle's output; pipe_we ignored during the stall.
- WAW in HOLD: buffer r5=0xAA, then a pipeline commit to r5=0xBB → only r5=0xBB written; pend_valid drops; drop_cnt=1.
- Same-cycle WAW: pipe rd=6 and LL rd=6 together → only the pipeline value written; ll_ready=1; drop_cnt increments; state stays IDLE.
- Reset mid-HOLD: assert rst_n=0 asynchronously mid-cycle while pend_valid=1 → all outputs 0 immediately; after release no pending write occurs and ll_ready=1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants for the writeback-port arbiter: FSM encoding, default
// register-index width and the hard-wired zero register.
package wb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] FORCE = 2'd2;

  localparam int REG_BITS_DEF = 5;
  localparam int X0           = 0;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding buffer for a deferred long-latency result.
// Capture wins over clear/invalidate when both are requested.
module wb_hold_buf
  import wb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = REG_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                capture,
  input  logic                clear,
  input  logic                invalidate,
  input  logic [REG_BITS-1:0] rd_in,
  input  logic [WIDTH-1:0]    data_in,
  output logic                valid,
  output logic [REG_BITS-1:0] rd,
  output logic [WIDTH-1:0]    data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      rd    <= rd_in;
      data  <= data_in;
    end else if (clear || invalidate) begin
      valid <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the WB-stage result
// and a long-latency unit, deferring at most one LL result and resolving WAW.
//
// state | meaning
// IDLE  | buffer empty, LL results accepted
// HOLD  | one LL result buffered, waiting for a free write slot
// FORCE | buffered result starved; pipeline stalled while it is written
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = REG_BITS_DEF,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pipe_we,
  input  logic [REG_BITS-1:0] pipe_rd,
  input  logic [WIDTH-1:0]    pipe_data,
  input  logic                ll_valid,
  output logic                ll_ready,
  input  logic [REG_BITS-1:0] ll_rd,
  input  logic [WIDTH-1:0]    ll_data,
  output logic                rf_we,
  output logic [REG_BITS-1:0] rf_waddr,
  output logic [WIDTH-1:0]    rf_wdata,
  output logic                pipe_stall,
  output logic                pend_valid,
  output logic [REG_BITS-1:0] pend_rd,
  output logic [CNT_W-1:0]    drop_cnt
);

  localparam logic [REG_BITS-1:0] RD_X0    = REG_BITS'(X0);
  localparam logic [3:0]          WAIT_LIM = 4'(MAX_WAIT);

  logic [1:0]          state, state_nxt;
  logic [3:0]          wait_cnt, wait_nxt;
  logic                commit, hs;
  logic                cap, clr, inval, drop;
  logic                we_nxt;
  logic [REG_BITS-1:0] addr_nxt;
  logic [WIDTH-1:0]    data_nxt;
  logic                buf_valid;
  logic [REG_BITS-1:0] buf_rd;
  logic [WIDTH-1:0]    buf_data;

  // Gated by rst_n so every output reads 0 while reset is held.
  assign ll_ready   = rst_n && (state == IDLE);
  assign pipe_stall = (state == FORCE);
  assign commit     = pipe_we && (pipe_rd != RD_X0) && !pipe_stall;
  assign hs         = ll_valid && ll_ready;
  assign pend_valid = buf_valid;
  assign pend_rd    = buf_rd;

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    cap       = 1'b0;
    clr       = 1'b0;
    inval     = 1'b0;
    drop      = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = '0;
    data_nxt  = '0;
    case (state)
      FORCE: begin
        we_nxt    = 1'b1;
        addr_nxt  = buf_rd;
        data_nxt  = buf_data;
        clr       = 1'b1;
        wait_nxt  = '0;
        state_nxt = IDLE;
      end
      HOLD: begin
        if (!commit) begin
          we_nxt    = 1'b1;
          addr_nxt  = buf_rd;
          data_nxt  = buf_data;
          clr       = 1'b1;
          wait_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          we_nxt   = 1'b1;
          addr_nxt = pipe_rd;
          data_nxt = pipe_data;
          if (pipe_rd == buf_rd) begin
            // Younger pipeline write supersedes the buffered result.
            inval     = 1'b1;
            drop      = 1'b1;
            wait_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            wait_nxt = wait_cnt + 4'd1;
            if (wait_nxt == WAIT_LIM) state_nxt = FORCE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        wait_nxt  = '0;
        if (commit) begin
          we_nxt   = 1'b1;
          addr_nxt = pipe_rd;
          data_nxt = pipe_data;
          if (hs && (ll_rd != RD_X0)) begin
            if (ll_rd == pipe_rd) begin
              drop = 1'b1;
            end else begin
              cap       = 1'b1;
              state_nxt = HOLD;
            end
          end
        end else if (hs && (ll_rd != RD_X0)) begin
          we_nxt   = 1'b1;
          addr_nxt = ll_rd;
          data_nxt = ll_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      rf_we    <= we_nxt;
      rf_waddr <= addr_nxt;
      rf_wdata <= data_nxt;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  wb_hold_buf #(
    .WIDTH    (WIDTH),
    .REG_BITS (REG_BITS)
  ) u_hold_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture    (cap),
    .clear      (clr),
    .invalidate (inval),
    .rd_in      (ll_rd),
    .data_in    (ll_data),
    .valid      (buf_valid),
    .rd         (buf_rd),
    .data       (buf_data)
  );

endmodule
